// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between execute and a word-organised data RAM.
// Accepts one request at a time (valid/ready), steers store bytes onto lanes,
// issues loads to a 1-cycle-latency RAM and extends the returned data, flags
// misaligned/illegal/out-of-range accesses, and returns every result through
// a registered one-entry response slot with back-pressure.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*_i / req_ready_o  request channel (we, memop, addr, wdata, rd tag)
//   mem_*_o / mem_rdata_i  RAM port (strobe, byte enables, word index, data)
//   resp_*_o / resp_ready_i response channel (rdata, rd, err, is_load)
module dmem_lsu #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_memop_i,
  input  logic [XLEN-1:0]       req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [DEPTH_LOG2-1:0] mem_addr_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic [XLEN-1:0]       mem_rdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_rdata_o,
  output logic [4:0]            resp_rd_o,
  output logic                  resp_err_o,
  output logic                  resp_is_load_o
);

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic {IDLE, LOAD_WAIT} state_e;

  state_e          state_q, state_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]      resp_rd_q, resp_rd_d;
  logic            resp_err_q, resp_err_d;
  logic            resp_is_load_q, resp_is_load_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic [2:0]      ld_op_q, ld_op_d;
  logic [4:0]      ld_rd_q, ld_rd_d;

  logic            accept;
  logic            req_err_c;
  logic [3:0]      st_we_c;
  logic [XLEN-1:0] st_wdata_c;
  logic [XLEN-1:0] ld_data_c;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // Request classification: any one condition makes the access an error.
  always_comb begin
    logic illegal, misaligned, out_of_range;
    illegal      = (req_memop_i inside {3'b011, 3'b110, 3'b111}) ||
                   (req_we_i && req_memop_i[2]);
    misaligned   = ((req_memop_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_memop_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    out_of_range = (req_addr_i >> (DEPTH_LOG2 + 2)) != '0;
    req_err_c    = illegal || misaligned || out_of_range;
  end

  // Store lane steering: replicate the datum and enable only the target lanes.
  always_comb begin
    st_we_c    = 4'b1111;
    st_wdata_c = req_wdata_i;
    case (req_memop_i[1:0])
      2'b00: begin
        st_we_c    = 4'b0001 << req_addr_i[1:0];
        st_wdata_c = XLEN'({4{req_wdata_i[7:0]}});
      end
      2'b01: begin
        st_we_c    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = XLEN'({2{req_wdata_i[15:0]}});
      end
      default: ;
    endcase
  end

  // Load extraction from the RAM word using the offset/op latched at accept.
  always_comb begin
    ld_byte = mem_rdata_i[{ld_off_q, 3'b000} +: 8];
    ld_half = ld_off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (ld_op_q)
      MOP_B:   ld_data_c = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      MOP_H:   ld_data_c = {{(XLEN-16){ld_half[15]}}, ld_half};
      MOP_BU:  ld_data_c = {{(XLEN-8){1'b0}}, ld_byte};
      MOP_HU:  ld_data_c = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data_c = mem_rdata_i;
    endcase
  end

  // Next-state, RAM strobes and response-slot update.
  always_comb begin
    state_d        = state_q;
    resp_valid_d   = resp_valid_q && !resp_ready_i;
    resp_rdata_d   = resp_rdata_q;
    resp_rd_d      = resp_rd_q;
    resp_err_d     = resp_err_q;
    resp_is_load_d = resp_is_load_q;
    ld_off_d       = ld_off_q;
    ld_op_d        = ld_op_q;
    ld_rd_d        = ld_rd_q;
    mem_en_o       = 1'b0;
    mem_we_o       = 4'b0000;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    req_ready_o    = (state_q == IDLE) && (!resp_valid_q || resp_ready_i);
    // rst_n gate keeps the RAM quiet while reset is held
    accept         = req_valid_i && req_ready_o && rst_n;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err_c) begin
            resp_valid_d   = 1'b1;
            resp_rdata_d   = '0;
            resp_rd_d      = req_rd_i;
            resp_err_d     = 1'b1;
            resp_is_load_d = ~req_we_i;
          end else if (req_we_i) begin
            mem_en_o       = 1'b1;
            mem_we_o       = st_we_c;
            mem_addr_o     = req_addr_i[DEPTH_LOG2+1:2];
            mem_wdata_o    = st_wdata_c;
            resp_valid_d   = 1'b1;
            resp_rdata_d   = '0;
            resp_rd_d      = req_rd_i;
            resp_err_d     = 1'b0;
            resp_is_load_d = 1'b0;
          end else begin
            mem_en_o   = 1'b1;
            mem_addr_o = req_addr_i[DEPTH_LOG2+1:2];
            ld_off_d   = req_addr_i[1:0];
            ld_op_d    = req_memop_i;
            ld_rd_d    = req_rd_i;
            state_d    = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        // slot is guaranteed free here: accept required it empty or draining
        resp_valid_d   = 1'b1;
        resp_rdata_d   = ld_data_c;
        resp_rd_d      = ld_rd_q;
        resp_err_d     = 1'b0;
        resp_is_load_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, response slot and latched load context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_rd_q      <= '0;
      resp_err_q     <= 1'b0;
      resp_is_load_q <= 1'b0;
      ld_off_q       <= '0;
      ld_op_q        <= '0;
      ld_rd_q        <= '0;
    end else begin
      state_q        <= state_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_rd_q      <= resp_rd_d;
      resp_err_q     <= resp_err_d;
      resp_is_load_q <= resp_is_load_d;
      ld_off_q       <= ld_off_d;
      ld_op_q        <= ld_op_d;
      ld_rd_q        <= ld_rd_d;
    end
  end

  assign resp_valid_o   = resp_valid_q;
  assign resp_rdata_o   = resp_rdata_q;
  assign resp_rd_o      = resp_rd_q;
  assign resp_err_o     = resp_err_q;
  assign resp_is_load_o = resp_is_load_q;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the execute stage and the word-organised data RAM. It accepts one memory request at a time over a valid/ready handshake. For stores it steers bytes onto lanes and drives byte enables. For loads it issues a read to the 1-cycle-latency RAM, then extracts and sign- or zero-extends the result. It flags misaligned, illegal and out-of-range accesses and returns every request's result over a registered, back-pressurable response channel.

Parameters:
DEPTH_LOG2, 10, RAM depth as log2 of the word count; word index = addr[DEPTH_LOG2+1:2]
XLEN, 32, data and address width

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_memop  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits used for B/H)
req_rd  in  5  destination tag, returned unchanged
mem_en  out  1  RAM access strobe
mem_we  out  4  per-byte write enables
mem_addr  out  DEPTH_LOG2  word index
mem_wdata  out  32  lane-steered store data
mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we==0
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_rd  out  5  tag of the completed request
resp_err  out  1  misaligned, illegal or out-of-range
resp_is_load  out  1  response belongs to a load

Behaviour:
- States: IDLE, LOAD_WAIT. Output register (the resp_* signals) is a one-entry slot.
- req_ready = (state==IDLE) && (!resp_valid || resp_ready).
- Accept cycle T. The request is classified combinationally from req_*. mem_* is driven in cycle T only for legal accepted requests; otherwise mem_en=0 and mem_we=0.
- Error checks, any one sets err:
  - memop in {011,110,111};
  - store with memop 100 or 101;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - addr[31:DEPTH_LOG2+2] nonzero.
- On error there is no RAM access. The response loads at end of T: err=1, rdata=0, is_load=~req_we. resp_valid is high in T+1.
- Store steering:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_we=4'b0001<<addr[1:0].
  - SH: {2{wdata[15:0]}}, mem_we=0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: wdata, 1111.
  - Response loads at end of T: err=0, rdata=0, is_load=0. resp_valid is high in T+1.
- Load: mem_en=1, mem_we=0 in T; state goes to LOAD_WAIT.
  - In T+1, extract from mem_rdata: the byte at lane addr[1:0] or the half at addr[1], sign-extended for B/H, zero-extended for BU/HU, whole word for W. Store the result into the response slot.
  - Return to IDLE at end of T+1. resp_valid is high in T+2.
  - addr[1:0], memop and rd are latched at accept.
- Load-to-response latency is 2 cycles; store/error latency is 1 cycle. Peak throughput is 1 store per cycle, or 1 load per 2 cycles.
- Response slot: resp_valid is cleared on resp_valid&&resp_ready unless a new result loads in the same edge, in which case the new result wins. All resp_* stay stable while valid&&!ready.
- LOAD_WAIT always finds the slot free, because accept required it to be empty or draining. req_ready=0 throughout LOAD_WAIT.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_rd=0, resp_err=0, resp_is_load=0. mem_en and mem_we are 0 while rst_n=0.
- Reset mid-operation: an in-flight load is dropped with no response. A pending response is discarded.

Test Plan:
- Store then load: SW addr 0x10 data 0xDEADBEEF, then LW 0x10. Required: mem_we=1111, mem_addr=4; store resp in T+1 with rdata=0; load resp_rdata=0xDEADBEEF two cycles after accept.
- Sub-word loads: word 0x80F0_7F01 at 0x20. Required:
  - LB 0x23 -> 0xFFFFFF80;
  - LBU 0x23 -> 0x00000080;
  - LH 0x22 -> 0xFFFF80F0;
  - LHU 0x20 -> 0x00007F01;
  - LB 0x21 -> 0x0000007F.
- Byte/half store steering: SB 0x31 wdata 0x000000AB -> mem_we=0010, mem_wdata=0xABABABAB. SH 0x32 wdata 0x1234 -> mem_we=1100, mem_wdata=0x12341234.
- Errors: each of LW 0x42, SH 0x41, memop 011, store memop 100, LW 0x00001000 (DEPTH_LOG2=10) -> mem_en never asserted, resp_err=1 one cycle after accept, rdata=0.
- Back-pressure: hold resp_ready=0 after LW completes. Required: resp_* stable, req_ready=0. Release resp_ready: the next SW is accepted in the same cycle the response drains, and its response appears the following cycle.
- Reset mid-load: assert rst_n=0 in the LOAD_WAIT cycle. Required: resp_valid=0 immediately; no response after release; req_ready=1 on the first post-reset cycle.
